reg_file_rename: RTL and testbench

- Architectural register file with per-register rename tags. Sits directly downstream of the ROB.
- Consumes the ROB's issue-time rename (destination register to ROB entry) and its in-order commit writes.
- Serves two source-operand lookups to the issue/dispatch logic, returning either a ready value or the ROB tag to wait on.
- Supports a full rename flush on misprediction or JALR recovery.

---
 rtl/reg_file_rename.sv | 88 ++++++++
 tb/tb_reg_file_rename.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags and two source lookups.
// Optional macro REG_COMMIT_FWD_EN forwards a same-cycle matching commit onto the lookups.
module reg_file_rename #(
  parameter int REG_BIT = 5,
  parameter int ROB_BIT = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               rename_valid,
  input  logic [REG_BIT-1:0] rename_rd,
  input  logic [ROB_BIT-1:0] rename_entry,
  input  logic               commit_valid,
  input  logic [REG_BIT-1:0] commit_rd,
  input  logic [ROB_BIT-1:0] commit_entry,
  input  logic [31:0]        commit_value,
  input  logic               flush,
  input  logic [REG_BIT-1:0] rs1_id,
  input  logic [REG_BIT-1:0] rs2_id,
  output logic [31:0]        rs1_value,
  output logic               rs1_busy,
  output logic [ROB_BIT-1:0] rs1_tag,
  output logic [31:0]        rs2_value,
  output logic               rs2_busy,
  output logic [ROB_BIT-1:0] rs2_tag
);

  localparam int unsigned NREG = 1 << REG_BIT;

  logic [31:0]        value_q [NREG];
  logic               busy_q  [NREG];
  logic [ROB_BIT-1:0] tag_q   [NREG];

  logic rename_ok;
  logic commit_ok;

  assign rename_ok = rename_valid && (rename_rd != '0) && !flush;
  assign commit_ok = commit_valid && (commit_rd != '0);

  // x0 is never written, so its reset-cleared state holds forever.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (commit_ok) begin
        value_q[commit_rd] <= commit_value;
        if (tag_q[commit_rd] == commit_entry)
          busy_q[commit_rd] <= 1'b0;
      end
      // Later assignment wins: a same-cycle rename re-marks the register busy.
      if (rename_ok) begin
        busy_q[rename_rd] <= 1'b1;
        tag_q[rename_rd]  <= rename_entry;
      end
      if (flush) begin
        for (int unsigned i = 0; i < NREG; i++)
          busy_q[i] <= 1'b0;
      end
    end
  end

  logic fwd1;
  logic fwd2;

`ifdef REG_COMMIT_FWD_EN
  assign fwd1 = rdy_in && commit_ok && (commit_rd == rs1_id) &&
                busy_q[rs1_id] && (tag_q[rs1_id] == commit_entry);
  assign fwd2 = rdy_in && commit_ok && (commit_rd == rs2_id) &&
                busy_q[rs2_id] && (tag_q[rs2_id] == commit_entry);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  always_comb begin
    rs1_value = fwd1 ? commit_value : value_q[rs1_id];
    rs1_busy  = busy_q[rs1_id] && !fwd1;
    rs1_tag   = tag_q[rs1_id];
    rs2_value = fwd2 ? commit_value : value_q[rs2_id];
    rs2_busy  = busy_q[rs2_id] && !fwd2;
    rs2_tag   = tag_q[rs2_id];
  end

endmodule

// File: tb/tb_reg_file_rename.sv
// Self-checking bench for reg_file_rename: directed scenarios then random traffic vs. an array model.
// Honours REG_COMMIT_FWD_EN the same way the design does.
module tb_reg_file_rename;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        rename_valid = 1'b0;
  logic [4:0]  rename_rd = '0;
  logic [3:0]  rename_entry = '0;
  logic        commit_valid = 1'b0;
  logic [4:0]  commit_rd = '0;
  logic [3:0]  commit_entry = '0;
  logic [31:0] commit_value = '0;
  logic        flush = 1'b0;
  logic [4:0]  rs1_id = '0;
  logic [4:0]  rs2_id = '0;
  logic [31:0] rs1_value, rs2_value;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_tag, rs2_tag;

  int total = 0;
  int bad = 0;

  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  reg_file_rename #(.REG_BIT(5), .ROB_BIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rename_valid(rename_valid), .rename_rd(rename_rd), .rename_entry(rename_entry),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_entry(commit_entry),
    .commit_value(commit_value), .flush(flush),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_value(rs1_value), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
    .rs2_value(rs2_value), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic check_port(input string nm, input logic [4:0] id, input logic [31:0] gv,
                            input logic gb, input logic [3:0] gt);
    logic [31:0] ev; logic eb; logic [3:0] et; bit fwd;
    ev = m_val[id]; eb = m_busy[id]; et = m_tag[id];
    fwd = 1'b0;
`ifdef REG_COMMIT_FWD_EN
    fwd = rdy_in && commit_valid && (commit_rd == id) && (id != 0) && eb && (et == commit_entry);
`endif
    if (fwd) begin ev = commit_value; eb = 1'b0; end
    chk({nm, "_value"}, gv, ev);
    chk({nm, "_busy"}, {31'b0, gb}, {31'b0, eb});
    if (eb || id == 0) chk({nm, "_tag"}, {28'b0, gt}, {28'b0, et});
  endtask

  // Spec rules applied to the model at the active edge, using the held inputs.
  task automatic model_update();
    bit ren_ok;
    if (!rdy_in) return;
    ren_ok = rename_valid && rename_rd != 0 && !flush;
    if (commit_valid && commit_rd != 0) begin
      m_val[commit_rd] = commit_value;
      if (m_tag[commit_rd] == commit_entry && !(ren_ok && rename_rd == commit_rd))
        m_busy[commit_rd] = 1'b0;
    end
    if (ren_ok) begin
      m_busy[rename_rd] = 1'b1; m_tag[rename_rd] = rename_entry;
    end
    if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  task automatic step(input logic rv, input logic [4:0] rd, input logic [3:0] re,
                      input logic cv, input logic [4:0] crd, input logic [3:0] ce,
                      input logic [31:0] cval, input logic fl,
                      input logic [4:0] r1, input logic [4:0] r2, input logic rdy);
    @(negedge clk_in);
    rename_valid = rv; rename_rd = rd; rename_entry = re;
    commit_valid = cv; commit_rd = crd; commit_entry = ce; commit_value = cval;
    flush = fl; rs1_id = r1; rs2_id = r2; rdy_in = rdy;
    #1;
    check_port("rs1", rs1_id, rs1_value, rs1_busy, rs1_tag);
    check_port("rs2", rs2_id, rs2_value, rs2_busy, rs2_tag);
    @(posedge clk_in);
    model_update();
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2, 1);
  endtask

  initial begin
    model_clear();
    #12 rst_in = 1'b1;

    // 1: write x5, then asynchronous reset mid-cycle
    step(0, 0, 0, 1, 5, 0, 32'h1234, 0, 5, 0, 1);
    idle(5, 0);
    chk("t1_pre_val", rs1_value, 32'h1234);
    @(negedge clk_in); #2;
    rst_in = 1'b0; rs1_id = 5; commit_valid = 1'b0; rename_valid = 1'b0;
    #1;
    model_clear();
    chk("t1_rst_val", rs1_value, 32'h0);
    chk("t1_rst_busy", {31'b0, rs1_busy}, 32'h0);
    chk("t1_rst_tag", {28'b0, rs1_tag}, 32'h0);
    @(negedge clk_in); rst_in = 1'b1;

    // 2: rename x5 -> 3, commit entry 3
    step(1, 5, 3, 0, 0, 0, 0, 0, 5, 0, 1);
    idle(5, 0);
    chk("t2_busy", {31'b0, rs1_busy}, 32'h1);
    chk("t2_tag", {28'b0, rs1_tag}, 32'h3);
    step(0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0, 5, 0, 1);
    idle(5, 0);
    chk("t2_val", rs1_value, 32'hDEADBEEF);

    // 3: youngest producer wins
    step(1, 7, 2, 0, 0, 0, 0, 0, 7, 0, 1);
    step(1, 7, 6, 0, 0, 0, 0, 0, 7, 0, 1);
    step(0, 0, 0, 1, 7, 2, 32'h11, 0, 7, 7, 1);
    idle(7, 7);
    chk("t3_tag", {28'b0, rs1_tag}, 32'h6);
    step(0, 0, 0, 1, 7, 6, 32'h22, 0, 7, 7, 1);
    idle(7, 7);
    chk("t3_val", rs2_value, 32'h22);

    // 4: same-cycle rename and commit of x9
    step(1, 9, 1, 0, 0, 0, 0, 0, 9, 0, 1);
    step(1, 9, 4, 1, 9, 1, 32'h55, 0, 9, 0, 1);
    idle(9, 9);
    chk("t4_tag", {28'b0, rs1_tag}, 32'h4);

    // 5: flush with rename and commit
    step(1, 3, 1, 0, 0, 0, 0, 0, 3, 4, 1);
    step(1, 4, 2, 0, 0, 0, 0, 0, 3, 4, 1);
    step(1, 8, 7, 0, 0, 0, 0, 0, 8, 4, 1);
    step(1, 10, 5, 1, 4, 9, 32'h99, 1, 10, 4, 1);
    idle(3, 4); idle(8, 10);
    chk("t5_busy10", {31'b0, rs2_busy}, 32'h0);

    // 6: x0 ignored; commit-forwarding observation on rs2
    step(1, 0, 7, 1, 0, 7, 32'hFFFF, 0, 0, 0, 1);
    idle(0, 0);
    step(1, 5, 3, 0, 0, 0, 0, 0, 0, 5, 1);
    step(0, 0, 0, 1, 5, 3, 32'hAB, 0, 0, 5, 1);
    idle(0, 5);
    chk("t6_val", rs2_value, 32'hAB);

    // rdy_in low holds state and suppresses forwarding
    step(1, 12, 9, 0, 0, 0, 0, 0, 12, 0, 1);
    step(1, 12, 2, 1, 12, 9, 32'h77, 1, 12, 0, 0);
    idle(12, 12);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] crd;
      logic [3:0] ce;
      crd = 5'($urandom_range(0, 15));
      ce = ($urandom_range(0, 1) == 1) ? m_tag[crd] : 4'($urandom);
      step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)), 4'($urandom),
           $urandom_range(0, 1) == 1, crd, ce, $urandom,
           $urandom_range(0, 31) == 0,
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
           $urandom_range(0, 9) != 0);
    end
    idle(1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
